mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: none; all widths fixed as below.
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 rdy  in  1  global ready; 0 freezes all state.
REQ-005 w_addr_i  in  5  destination register from EX/MEM latch.
REQ-006 w_req_i  in  1  register write request from EX/MEM latch.
REQ-007 w_data_i  in  32  ALU result for non-memory ops; store data for stores.
REQ-008 mem_addr_i  in  32  byte address for loads/stores.
REQ-009 op_i  in  4  0=NOP, 1=LB, 2=LH, 3=LW, 4=LBU, 5=LHU, 6=SB, 7=SH, 8=SW, 9-15 treated as NOP-passthrough.
REQ-010 mc_req  out  1  byte access request to memory controller.
REQ-011 mc_we  out  1  1=write byte, 0=read byte.
REQ-012 mc_addr  out  32  byte address of current access.
REQ-013 mc_wdata  out  8  write byte.
REQ-014 mc_rdata  in  8  read byte, valid when mc_done=1.
REQ-015 mc_done  in  1  one-cycle pulse: current byte access complete.
REQ-016 stall_req  out  1  hold EX/MEM and earlier stages.
REQ-017 wb_addr  out  5  destination register to MEM/WB.
REQ-018 wb_req  out  1  register write request to MEM/WB.
REQ-019 wb_data  out  32  writeback data to MEM/WB.

Function
REQ-020 FSM states: IDLE, ACCESS, DONE; byte counter cnt (2 bits); data buffer buf (32 bits).
REQ-021 Access length n: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW.
REQ-022 IDLE with non-memory op: wb_addr=w_addr_i, wb_req=w_req_i, wb_data=w_data_i combinationally; stall_req=0; mc_req=0.
REQ-023 IDLE with load/store op: stall_req=1 same cycle; next state ACCESS, cnt=0, buf=0.
REQ-024 ACCESS: mc_req=1, mc_addr=mem_addr_i+cnt (32-bit wrap), mc_we=1 for stores, mc_wdata=w_data_i byte cnt (little-endian), stall_req=1.
REQ-025 ACCESS on mc_done: loads write mc_rdata into buf byte cnt; if cnt=n-1 next state DONE, else cnt+1.
REQ-026 mc_req deasserts the cycle after the final mc_done; mc_req stays high across intermediate bytes.
REQ-027 DONE: stall_req=0, mc_req=0; loads: wb_data=buf sign-extended (LB/LH) or zero-extended (LBU/LHU), LW unchanged; wb_req=w_req_i; stores: wb_req=0; next state IDLE unconditionally.
REQ-028 DONE never restarts an access even though op_i is still the same memory op.
REQ-029 Memory-op latency: n byte handshakes + 1 cycle; minimum for LW with zero-wait mc_done: 6 cycles from op arrival to IDLE.
REQ-030 In ACCESS, wb_req=0.
REQ-031 rdy=0: state, cnt, buf hold; mc_done ignored that cycle; outputs reflect held state.
REQ-032 mc_done while not in ACCESS is ignored.

Reset
REQ-033 rst=0 asynchronously forces state IDLE, cnt=0, buf=0; registered outputs return to 0; mc_req=0.
REQ-034 Reset mid-ACCESS abandons the transaction; no partial writeback occurs after reset release.

Verification
REQ-035 op=NOP-passthrough, w_addr=5, w_req=1, w_data=0x1234 -> wb_*=5/1/0x1234 same cycle, stall_req=0.
REQ-036 LB addr=0x100, mc_rdata=0x80 -> one access at 0x100 read; DONE wb_data=0xFFFFFF80, stall_req high 2 cycles.
REQ-037 LW addr=0x200, bytes 0x78,0x56,0x34,0x12 with 2-cycle waits -> mc_addr 0x200..0x203, wb_data=0x12345678.
REQ-038 SH addr=0x10, w_data=0xAABBCCDD -> writes 0xDD@0x10, 0xCC@0x11, wb_req=0 in DONE.
REQ-039 LHU with rdy=0 held 3 cycles between bytes -> no extra accesses, wb_data=0x0000xxxx correct.
REQ-040 rst low after first LW byte -> mc_req=0 immediately, state IDLE, stall_req follows op_i after release.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: byte-serial load/store stage between EX/MEM and MEM/WB
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [4:0]  w_addr_i,
    input  logic        w_req_i,
    input  logic [31:0] w_data_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  op_i,
    output logic        mc_req,
    output logic        mc_we,
    output logic [31:0] mc_addr,
    output logic [7:0]  mc_wdata,
    input  logic [7:0]  mc_rdata,
    input  logic        mc_done,
    output logic        stall_req,
    output logic [4:0]  wb_addr,
    output logic        wb_req,
    output logic [31:0] wb_data
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
    logic [1:0]  state, cnt;
    logic [31:0] data_buf;
    logic        is_load, is_store, is_mem, in_idle, in_access, in_done;
    logic [1:0]  last_cnt;
    logic [31:0] load_data;
    assign is_load   = op_i >= 4'd1 && op_i <= 4'd5;
    assign is_store  = op_i >= 4'd6 && op_i <= 4'd8;
    assign is_mem    = is_load || is_store;
    assign in_idle   = state == IDLE;
    assign in_access = state == ACCESS;
    assign in_done   = state == DONE;
    assign last_cnt  = (op_i == 4'd3 || op_i == 4'd8) ? 2'd3 :
                       (op_i == 4'd2 || op_i == 4'd5 || op_i == 4'd7) ? 2'd1 : 2'd0;
    assign load_data = op_i == 4'd1 ? {{24{data_buf[7]}}, data_buf[7:0]} :
                       op_i == 4'd2 ? {{16{data_buf[15]}}, data_buf[15:0]} :
                       op_i == 4'd4 ? {24'd0, data_buf[7:0]} :
                       op_i == 4'd5 ? {16'd0, data_buf[15:0]} : data_buf;
    assign mc_req    = in_access;
    assign mc_we     = in_access && is_store;
    assign mc_addr   = mem_addr_i + {30'd0, cnt};
    assign mc_wdata  = w_data_i[{cnt, 3'b000} +: 8];
    assign stall_req = in_access || (in_idle && is_mem);
    assign wb_addr   = w_addr_i;
    assign wb_req    = in_idle ? (!is_mem && w_req_i) : (in_done && is_load && w_req_i);
    assign wb_data   = in_idle ? (is_mem ? 32'd0 : w_data_i) : (in_done && is_load) ? load_data : 32'd0;
    // sequence one byte handshake per access; DONE always returns to IDLE so an op still held never restarts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            data_buf <= 32'd0;
        end else if (rdy) begin
            if (in_idle && is_mem) begin
                state    <= ACCESS;
                cnt      <= 2'd0;
                data_buf <= 32'd0;
            end else if (in_access && mc_done) begin
                if (is_load) data_buf[{cnt, 3'b000} +: 8] <= mc_rdata;
                if (cnt == last_cnt) state <= DONE;
                else cnt <= cnt + 2'd1;
            end else if (!in_idle && !in_access) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: transaction-level model plus directed vectors for mem_stage
module tb_mem_stage;
    logic        clk, rst, rdy, w_req_i, mc_req, mc_we, mc_done, stall_req, wb_req;
    logic [4:0]  w_addr_i, wb_addr;
    logic [31:0] w_data_i, mem_addr_i, mc_addr, wb_data;
    logic [3:0]  op_i;
    logic [7:0]  mc_wdata, mc_rdata;
    logic [7:0]  mem [0:1023];
    int          tests = 0, fails = 0, hs_count = 0, waits = 0, w_cnt = 0, stall_cnt = 0, hs_done = 0;
    logic        noise = 0, done_now;
    logic [31:0] last_addr, cap_data, raw, a;
    logic        cap_req;
    logic        m_active = 0, m_load, m_store;
    logic [3:0]  m_op;
    logic [31:0] m_addr, m_wd, m_exp;
    int          m_k, m_n;

    mem_stage dut (
        .clk(clk), .rst(rst), .rdy(rdy), .w_addr_i(w_addr_i), .w_req_i(w_req_i),
        .w_data_i(w_data_i), .mem_addr_i(mem_addr_i), .op_i(op_i), .mc_req(mc_req),
        .mc_we(mc_we), .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_rdata(mc_rdata),
        .mc_done(mc_done), .stall_req(stall_req), .wb_addr(wb_addr), .wb_req(wb_req),
        .wb_data(wb_data)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic is_mem_op(input logic [3:0] op);
        return op >= 4'd1 && op <= 4'd8;
    endfunction

    function automatic int op_len(input logic [3:0] op);
        return (op == 4'd3 || op == 4'd8) ? 4 : (op == 4'd2 || op == 4'd5 || op == 4'd7) ? 2 : 1;
    endfunction

    function automatic logic [31:0] extend(input logic [3:0] op, input logic [31:0] r);
        case (op)
            4'd1: return 32'($signed(r[7:0]));
            4'd2: return 32'($signed(r[15:0]));
            4'd4: return {24'd0, r[7:0]};
            4'd5: return {16'd0, r[15:0]};
            default: return r;
        endcase
    endfunction

    // per-cycle compare, memory responder and transaction model
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            m_active = 0;
            w_cnt = 0;
        end
        if (!m_active) begin
            chk("stall_idle", 32'(stall_req), 32'(is_mem_op(op_i)));
            chk("mc_req_idle", 32'(mc_req), 32'(0));
            chk("wb_req_idle", 32'(wb_req), is_mem_op(op_i) ? 32'd0 : 32'(w_req_i));
            if (!is_mem_op(op_i)) begin
                chk("wb_data_pass", wb_data, w_data_i);
                chk("wb_addr_pass", 32'(wb_addr), 32'(w_addr_i));
            end
        end else if (m_k < m_n) begin
            chk("stall_acc", 32'(stall_req), 32'd1);
            chk("mc_req_acc", 32'(mc_req), 32'd1);
            chk("wb_req_acc", 32'(wb_req), 32'd0);
            chk("mc_addr", mc_addr, m_addr + 32'(m_k));
            chk("mc_we", 32'(mc_we), 32'(m_store));
            if (m_store) chk("mc_wdata", 32'(mc_wdata), 32'(m_wd[8*m_k +: 8]));
        end else begin
            chk("stall_done", 32'(stall_req), 32'd0);
            chk("mc_req_done", 32'(mc_req), 32'd0);
            chk("wb_req_done", 32'(wb_req), 32'(m_load && w_req_i));
            if (m_load) chk("wb_data_load", wb_data, m_exp);
        end
        done_now = 0;
        mc_done = 0;
        mc_rdata = 8'hEE;
        if (rst && mc_req && rdy) begin
            if (w_cnt < waits) w_cnt++;
            else begin
                w_cnt = 0;
                done_now = 1;
                mc_done = 1;
                mc_rdata = mem[mc_addr[9:0]];
                if (mc_we) mem[mc_addr[9:0]] = mc_wdata;
                hs_count++;
                last_addr = mc_addr;
            end
        end else if (noise && rst) mc_done = 1;
        if (rst && rdy) begin
            if (!m_active) begin
                if (is_mem_op(op_i)) begin
                    m_active = 1;
                    m_k = 0;
                    m_op = op_i;
                    m_addr = mem_addr_i;
                    m_wd = w_data_i;
                    m_n = op_len(op_i);
                    m_load = op_i <= 4'd5;
                    m_store = op_i >= 4'd6;
                    raw = 0;
                    for (int i = 0; i < 4; i++) begin
                        a = m_addr + 32'(i);
                        if (i < m_n) raw[8*i +: 8] = mem[a[9:0]];
                    end
                    m_exp = extend(m_op, raw);
                end
            end else if (m_k < m_n) begin
                if (done_now) m_k++;
            end else m_active = 0;
        end
    end

    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd, input logic pause);
        int base;
        logic paused, fin;
        base = hs_count;
        paused = 0;
        fin = 0;
        stall_cnt = 0;
        op_i = op;
        mem_addr_i = addr;
        w_data_i = wd;
        w_addr_i = 5'd7;
        w_req_i = 1;
        for (int c = 0; c < 100 && !fin; c++) begin
            @(negedge clk);
            #1;
            if (pause && !paused && hs_count - base == 1) begin
                paused = 1;
                stall_cnt++;
                @(posedge clk);
                #1 rdy = 0;
                repeat (3) @(posedge clk);
                #1 rdy = 1;
            end else if (stall_req) stall_cnt++;
            else begin
                cap_req = wb_req;
                cap_data = wb_data;
                fin = 1;
            end
        end
        if (!fin) begin
            tests++;
            fails++;
            $display("FAIL timeout: op %0d never completed", op);
        end
        hs_done = hs_count - base;
        @(posedge clk);
        #1;
        op_i = 0;
        w_req_i = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 0; rdy = 1; op_i = 0; w_addr_i = 0; w_req_i = 0; w_data_i = 0; mem_addr_i = 0;
        mc_done = 0; mc_rdata = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[10'h100] = 8'h80;
        mem[10'h200] = 8'h78; mem[10'h201] = 8'h56; mem[10'h202] = 8'h34; mem[10'h203] = 8'h12;
        mem[10'h040] = 8'hF0; mem[10'h041] = 8'h9A;
        mem[10'h300] = 8'h34; mem[10'h301] = 8'h85;
        mem[10'h3FF] = 8'h11; mem[10'h000] = 8'h22;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mc_req", 32'(mc_req), 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_wb_req", 32'(wb_req), 32'd0);
        rst = 1;
        @(posedge clk);
        #1;
        op_i = 4'd9; w_addr_i = 5'd5; w_req_i = 1; w_data_i = 32'h1234;
        #1;
        chk("pass_wb_addr", 32'(wb_addr), 32'd5);
        chk("pass_wb_req", 32'(wb_req), 32'd1);
        chk("pass_wb_data", wb_data, 32'h1234);
        chk("pass_stall", 32'(stall_req), 32'd0);
        @(posedge clk);
        #1;
        op_i = 4'd15; w_data_i = 32'hDEAD0001;
        @(posedge clk);
        #1;
        do_op(4'd1, 32'h100, 32'h0, 0);
        chk("lb_data", cap_data, 32'hFFFFFF80);
        chk("lb_req", 32'(cap_req), 32'd1);
        chk("lb_stall", stall_cnt, 2);
        chk("lb_hs", hs_done, 1);
        do_op(4'd4, 32'h100, 32'h0, 0);
        chk("lbu_data", cap_data, 32'h00000080);
        waits = 2;
        do_op(4'd3, 32'h200, 32'h0, 0);
        chk("lw_wait_data", cap_data, 32'h12345678);
        chk("lw_wait_hs", hs_done, 4);
        chk("lw_last_addr", last_addr, 32'h203);
        waits = 0;
        do_op(4'd3, 32'h200, 32'h0, 0);
        chk("lw_stall", stall_cnt, 5);
        do_op(4'd7, 32'h10, 32'hAABBCCDD, 0);
        chk("sh_wb_req", 32'(cap_req), 32'd0);
        chk("sh_b0", 32'(mem[10'h10]), 32'hDD);
        chk("sh_b1", 32'(mem[10'h11]), 32'hCC);
        chk("sh_b2", 32'(mem[10'h12]), 32'h48);
        chk("sh_hs", hs_done, 2);
        noise = 1;
        do_op(4'd5, 32'h40, 32'h0, 1);
        chk("lhu_data", cap_data, 32'h00009AF0);
        chk("lhu_hs", hs_done, 2);
        do_op(4'd2, 32'h300, 32'h0, 0);
        chk("lh_data", cap_data, 32'hFFFF8534);
        noise = 0;
        do_op(4'd2, 32'hFFFFFFFF, 32'h0, 0);
        chk("lh_wrap", cap_data, 32'h00002211);
        do_op(4'd8, 32'h20, 32'hCAFEF00D, 0);
        do_op(4'd3, 32'h20, 32'h0, 0);
        chk("sw_lw", cap_data, 32'hCAFEF00D);
        do_op(4'd6, 32'h30, 32'h12345677, 0);
        chk("sb_b0", 32'(mem[10'h30]), 32'h77);
        chk("sb_b1", 32'(mem[10'h31]), 32'h6B);
        op_i = 4'd3; mem_addr_i = 32'h200; w_req_i = 1; w_data_i = 32'h0BAD;
        base = hs_count;
        for (int c = 0; c < 50 && hs_count - base < 1; c++) begin
            @(negedge clk);
            #1;
        end
        chk("rst_test_hs", hs_count - base, 1);
        @(negedge clk);
        #1 rst = 0;
        #1;
        chk("rst_mid_mc_req", 32'(mc_req), 32'd0);
        chk("rst_mid_stall", 32'(stall_req), 32'd1);
        op_i = 4'd0;
        #1;
        chk("rst_mid_stall_nop", 32'(stall_req), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        #1;
        chk("post_rst_wb_req", 32'(wb_req), 32'd1);
        chk("post_rst_wb_data", wb_data, 32'h0BAD);
        chk("post_rst_mc_req", 32'(mc_req), 32'd0);
        @(posedge clk);
        #1;
        do_op(4'd1, 32'h100, 32'h0, 0);
        chk("lb_after_rst", cap_data, 32'hFFFFFF80);
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
